adel_imem_loader: RTL
=====================

// Module: adel_imem_loader
// PURPOSE
//  Instruction store and program loader for the adel core. Accepts a byte stream (valid/ready),
//  packs byte pairs into 16-bit instruction words in a DEPTH-entry memory, and holds the core in
//  reset while loading. In RUN, returns inst = mem[pc] to the core combinationally.
// PARAMETERS
//  DEPTH  256  instruction words; power of two, 2..256
//  AW     8    address width = $clog2(DEPTH); matches core pc width
//  IW     16   instruction width; fixed at 2 bytes
// PORTS
//  clk        in   1     single clock; all state updates on posedge
//  rst        in   1     reset; synchronous, active-high
//  ld_start   in   1     one-cycle pulse: begin (or restart) a program load at address 0
//  ld_data    in   8     load byte; low byte of each word first
//  ld_valid   in   1     ld_data valid
//  ld_last    in   1     qualifies the final byte of the program
//  ld_ready   out  1     loader accepts a byte when ld_valid & ld_ready
//  pc         in   AW    core program counter
//  inst       out  IW    instruction at pc, to the core
//  core_nrst  out  1     active-low reset to the core
//  ld_busy    out  1     high while in LD_LO or LD_HI
//  ld_count   out  AW+1  words written by the current or last load, 0..DEPTH
//  ld_err     out  1     sticky error flag; cleared by rst or ld_start
// BEHAVIOUR
//  States: IDLE, LD_LO, LD_HI, RUN.
//  Reset values: state = IDLE, ld_ready = 0, core_nrst = 0, ld_busy = 0, ld_count = 0,
//  ld_err = 0, write address = 0. All memory words are cleared to 16'h0000.
//  IDLE: ld_start -> LD_LO. The core stays in reset.
//  LD_LO: ld_ready = 1. An accepted byte is held as the low byte.
//   - ld_last = 0 -> LD_HI.
//   - ld_last = 1 -> error: write {8'h00, byte}, set ld_err, go to RUN.
//  LD_HI: ld_ready = 1. An accepted byte writes {byte, lo} at the write address, then
//  address++ and ld_count++.
//   - ld_last = 0 -> LD_LO.
//   - ld_last = 1 -> RUN.
//  Write timing: the write occurs on the accepting edge. The word is readable on the next cycle.
//  Overflow: once ld_count == DEPTH, further words are not written, ld_err is set,
//  and the address does not wrap. The byte handshake continues until ld_last.
//  core_nrst: 0 in IDLE, LD_LO and LD_HI. Rises on the first clock in RUN, which is one cycle
//  after the last write.
//  inst: 16'h0000 while core_nrst = 0. In RUN, inst = mem[pc] with zero-cycle latency
//  (asynchronous read). An out-of-range pc (>= DEPTH) reads 16'h0000.
//  ld_start in any state, including mid-load and RUN, takes priority over everything:
//   - next state LD_LO; address, ld_count and ld_err cleared;
//   - any pending low byte is dropped, and a byte presented in the same cycle is not accepted;
//   - core_nrst goes low the next cycle; memory contents are kept.
//  rst mid-load: behaves as power-up reset, and memory is cleared.
//  ld_ready is a registered function of state only. It never depends on ld_valid.
// STRUCTURE
//  Package adel_pkg:
//   - IW and AW constants;
//   - enum ld_state_t {IDLE, LD_LO, LD_HI, RUN};
//   - NOP_HALT = 16'h0000.
//  Sub-module adel_imem: DEPTH x IW array, 1 sync write port, 1 async read port, sync clear on rst.
//  This module holds the FSM, the byte packer, the counters and the core reset control.
// TESTING
//  1. Reset check: rst for 2 cycles, then release.
//     -> core_nrst = 0, ld_ready = 0, inst = 0000, ld_count = 0.
//  2. Normal load: ld_start, then bytes 34,12,CD,AB(last).
//     -> mem[0] = 1234, mem[1] = ABCD, ld_count = 2;
//     -> core_nrst = 1 exactly 1 cycle after the last byte;
//     -> pc = 1 gives inst = ABCD.
//  3. Backpressure and gaps: ld_valid toggled randomly, and ld_valid held during IDLE.
//     -> no bytes are accepted in IDLE, and the image is identical to test 2.
//  4. Odd length: bytes 11,22,33(last).
//     -> mem[1] = 0033, ld_err = 1, state RUN.
//  5. Overflow with DEPTH = 4: 5 words loaded.
//     -> mem[0..3] hold words 0..3, ld_count = 4, ld_err = 1;
//     -> mem[0] is not overwritten.
//  6. Restart: ld_start after byte 3 of a load, then a fresh 2-word load.
//     -> ld_count = 2, ld_err = 0, stale low byte discarded;
//     -> ld_start in RUN drops core_nrst the next cycle.

Source files
------------

// File: rtl/adel_pkg.sv
// Shared types and constants for the adel instruction store and loader.
package adel_pkg;

  localparam int unsigned IW = 16;
  localparam int unsigned AW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LD_LO = 2'd1,
    LD_HI = 2'd2,
    RUN   = 2'd3
  } ld_state_t;

  localparam logic [15:0] NOP_HALT = 16'h0000;

endpackage

// File: rtl/adel_imem.sv
// Instruction memory: one synchronous write port, one asynchronous read port,
// whole array cleared synchronously on rst.
module adel_imem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned IW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  // Clear on reset, otherwise write one word on we.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read; addresses beyond DEPTH read as zero.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/adel_imem_loader.sv
// Program loader for the adel core: packs a byte stream into 16-bit words,
// holds the core in reset while loading, and serves inst = mem[pc] in RUN.
module adel_imem_loader
  import adel_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned IW    = adel_pkg::IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [7:0]    ld_data,
  input  logic          ld_valid,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] inst,
  output logic          core_nrst,
  output logic          ld_busy,
  output logic [AW:0]   ld_count,
  output logic          ld_err
);

  ld_state_t     state;
  logic [7:0]    lo;
  logic          accept;
  logic          full;
  logic          we;
  logic [IW-1:0] wdata;
  logic [IW-1:0] rdata;

  // The word count doubles as the write address: each word lands at the
  // index equal to the number already written, and writes stop at DEPTH
  // so the address never wraps.
  assign full   = (ld_count == (AW+1)'(DEPTH));
  assign accept = ld_valid & ld_ready & ~ld_start;

  // Memory write strobe and packed word for the current byte.
  always_comb begin
    we    = 1'b0;
    wdata = '0;
    if (accept && !full) begin
      if (state == LD_HI) begin
        we    = 1'b1;
        wdata = IW'({ld_data, lo});
      end else if (state == LD_LO && ld_last) begin
        we    = 1'b1;
        wdata = IW'({8'h00, ld_data});
      end
    end
  end

  adel_imem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (ld_count[AW-1:0]),
    .wdata (wdata),
    .raddr (pc),
    .rdata (rdata)
  );

  // Loader FSM with registered handshake, busy, count, error and core reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lo        <= '0;
      ld_count  <= '0;
      ld_err    <= 1'b0;
      ld_ready  <= 1'b0;
      ld_busy   <= 1'b0;
      core_nrst <= 1'b0;
    end else if (ld_start) begin
      state     <= LD_LO;
      lo        <= '0;
      ld_count  <= '0;
      ld_err    <= 1'b0;
      ld_ready  <= 1'b1;
      ld_busy   <= 1'b1;
      core_nrst <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ld_ready  <= 1'b0;
          ld_busy   <= 1'b0;
          core_nrst <= 1'b0;
        end
        LD_LO: begin
          if (accept) begin
            lo <= ld_data;
            if (ld_last) begin
              state    <= RUN;
              ld_err   <= 1'b1;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
            end else begin
              state <= LD_HI;
            end
          end
        end
        LD_HI: begin
          if (accept) begin
            if (full) begin
              ld_err <= 1'b1;
            end else begin
              ld_count <= ld_count + 1'b1;
            end
            if (ld_last) begin
              state    <= RUN;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
            end else begin
              state <= LD_LO;
            end
          end
        end
        RUN: begin
          core_nrst <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The core sees a halt word whenever it is held in reset.
  assign inst = core_nrst ? rdata : IW'(NOP_HALT);

endmodule
